fifo_reader: RTL and testbench

Read-side controller for the team's synchronous 8-bit FIFO: pops a programmed number of bytes using the FIFO's `r_en`/`empty` interface and hands each byte downstream on a valid/ready stream. It sits between the FIFO's read port and any byte consumer, such as a UART transmitter or a checker. It replaces hand-driven `r_en` sequencing and never underflows the FIFO.

---
 rtl/fifo_reader.sv | 127 ++++++++++++
 tb/tb_fifo_reader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: pops a programmed burst of bytes from a synchronous FIFO
// and forwards each one on a valid/ready stream, one byte in flight.
//
// Optional feature macro: FIFO_READER_CHECKSUM_EN
//   defined   -> running 8-bit sum of delivered bytes on checksum
//   undefined -> no accumulator; checksum tied to 0
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start, burst_len     burst request (pulse) and byte count
//   fifo_empty/data/r_en FIFO read port
//   m_data/valid/ready   output byte stream
//   busy, done           burst in progress / end-of-burst pulse
//   rd_count, checksum   bytes delivered and their sum
module fifo_reader #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_r_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  rd_count,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        CAPT,
        HOLD
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  remaining_q;
    logic [CNT_W-1:0]  rd_count_q;
    logic [DATA_W-1:0] m_data_q;
    logic              m_valid_q;
    logic              done_q;

    // Read only from REQ, so a pop can never overlap a held byte.
    assign fifo_r_en = (state_q == REQ) && !fifo_empty;

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign rd_count = rd_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            rd_count_q  <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        rd_count_q <= '0;
                        if (burst_len != '0) begin
                            remaining_q <= burst_len;
                            state_q     <= REQ;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (!fifo_empty) begin
                        state_q <= CAPT;
                    end
                end
                CAPT: begin
                    // FIFO presents the popped byte this cycle.
                    m_data_q  <= fifo_data;
                    m_valid_q <= 1'b1;
                    state_q   <= HOLD;
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid_q   <= 1'b0;
                        rd_count_q  <= rd_count_q + CNT_W'(1);
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FIFO_READER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if (state_q == IDLE && start && burst_len != '0) begin
            checksum_q <= '0;
        end else if (state_q == HOLD && m_ready) begin
            checksum_q <= checksum_q + m_data_q;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: scoreboard bench for fifo_reader with a
// behavioural FIFO model and a stalling downstream.
module tb_fifo_reader;

    localparam int DW = 8;
    localparam int CW = 8;

`ifdef FIFO_READER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] burst_len = '0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_r_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          busy;
    logic          done;
    logic [CW-1:0] rd_count;
    logic [DW-1:0] checksum;

    int npass = 0;
    int ntot  = 0;

    fifo_reader #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .burst_len  (burst_len),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done),
        .rd_count   (rd_count),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // FIFO model: data appears the cycle after an accepted pop.
    logic [DW-1:0] fq[$];
    int            fcnt = 0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    assign fifo_empty = (fcnt == 0);

    always @(posedge clk) begin : fifo_model
        int pop;
        pop = (fifo_r_en && !fifo_empty) ? 1 : 0;
        if (pop != 0) fifo_data <= fq.pop_front();
        if (wr_en) fq.push_back(wr_data);
        fcnt <= fcnt - pop + (wr_en ? 1 : 0);
    end

    // Downstream: optionally hold m_ready low 5 cycles per byte.
    bit stall = 1'b0;
    int hold_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (!stall) begin
            m_ready = 1'b1;
        end else if (m_valid) begin
            if (hold_cnt >= 5) begin
                m_ready = 1'b1;
                hold_cnt = 0;
            end else begin
                m_ready = 1'b0;
                hold_cnt++;
            end
        end else begin
            m_ready = 1'b0;
            hold_cnt = 0;
        end
    end

    // Scoreboard monitor.
    logic [DW-1:0] exp_q[$];
    int            ren_cnt = 0;
    int            done_cnt = 0;
    int            busy_rise = 0;
    logic          prev_busy = 1'b0;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy  = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (fifo_r_en) begin
                ren_cnt++;
                chk("ren_while_valid", {31'd0, m_valid}, 32'd0);
                chk("ren_while_empty", {31'd0, fifo_empty}, 32'd0);
            end
            if (done) done_cnt++;
            if (busy && !prev_busy) busy_rise++;
            if (prev_valid && !prev_ready && m_valid)
                chk("m_data_stable", {24'd0, m_data}, {24'd0, prev_data});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    ntot++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none",
                             m_data);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    chk("m_data", {24'd0, m_data}, {24'd0, e});
                end
            end
            prev_busy  = busy;
            prev_valid = m_valid;
            prev_ready = m_ready;
            prev_data  = m_data;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(logic [DW-1:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_start(logic [CW-1:0] len);
        start     = 1'b1;
        burst_len = len;
        tick();
        start     = 1'b0;
        burst_len = 8'hEE;
    endtask

    task automatic clr_cnt();
        ren_cnt   = 0;
        done_cnt  = 0;
        busy_rise = 0;
    endtask

    task automatic wait_done(string name, int maxc);
        bit seen;
        int i;
        seen = 1'b0;
        i = 0;
        while (!seen && i < maxc) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            i++;
        end
        chk({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        if (seen) chk({name, "_busy_low_at_done"}, {31'd0, busy}, 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        tick(2);
        chk("rst_r_en", {31'd0, fifo_r_en}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", {24'd0, m_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd_count", {24'd0, rd_count}, 32'd0);
        chk("rst_checksum", {24'd0, checksum}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Burst of 4, downstream always ready
        push(8'd10); push(8'd20); push(8'd30); push(8'd40);
        exp_q.push_back(8'd10); exp_q.push_back(8'd20);
        exp_q.push_back(8'd30); exp_q.push_back(8'd40);
        tick();
        clr_cnt();
        do_start(8'd4);
        chk("t1_r_en_n1", {31'd0, fifo_r_en}, 32'd1);
        tick();
        chk("t1_valid_n2", {31'd0, m_valid}, 32'd0);
        tick();
        chk("t1_valid_n3", {31'd0, m_valid}, 32'd1);
        wait_done("t1", 100);
        chk("t1_rd_count", {24'd0, rd_count}, 32'd4);
        chk("t1_checksum", {24'd0, checksum}, CK ? 32'd100 : 32'd0);
        chk("t1_done_cnt", done_cnt, 32'd1);
        chk("t1_ren_cnt", ren_cnt, 32'd4);
        chk("t1_exp_left", exp_q.size(), 32'd0);

        // Same preload, 5 stall cycles per byte
        stall = 1'b1;
        push(8'd10); push(8'd20); push(8'd30); push(8'd40);
        exp_q.push_back(8'd10); exp_q.push_back(8'd20);
        exp_q.push_back(8'd30); exp_q.push_back(8'd40);
        tick();
        clr_cnt();
        do_start(8'd4);
        wait_done("t2", 200);
        chk("t2_rd_count", {24'd0, rd_count}, 32'd4);
        chk("t2_done_cnt", done_cnt, 32'd1);
        chk("t2_ren_cnt", ren_cnt, 32'd4);
        chk("t2_exp_left", exp_q.size(), 32'd0);
        stall = 1'b0;
        tick();

        // Empty FIFO, bytes arrive late
        clr_cnt();
        exp_q.push_back(8'h55); exp_q.push_back(8'hAA);
        do_start(8'd2);
        tick(5);
        chk("t3_busy_waiting", {31'd0, busy}, 32'd1);
        chk("t3_no_ren_empty", ren_cnt, 32'd0);
        push(8'h55);
        tick(4);
        push(8'hAA);
        wait_done("t3", 100);
        chk("t3_rd_count", {24'd0, rd_count}, 32'd2);
        chk("t3_done_cnt", done_cnt, 32'd1);
        chk("t3_ren_cnt", ren_cnt, 32'd2);
        chk("t3_checksum", {24'd0, checksum}, CK ? 32'hFF : 32'd0);

        // Zero-length burst
        clr_cnt();
        do_start(8'd0);
        chk("t4_done_next", {31'd0, done}, 32'd1);
        chk("t4_busy_low", {31'd0, busy}, 32'd0);
        tick();
        chk("t4_done_one", {31'd0, done}, 32'd0);
        tick(3);
        chk("t4_busy_rise", busy_rise, 32'd0);
        chk("t4_ren_cnt", ren_cnt, 32'd0);
        chk("t4_rd_count", {24'd0, rd_count}, 32'd0);
        chk("t4_done_cnt", done_cnt, 32'd1);

        // Checksum wrap
        push(8'hFF); push(8'h02);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h02);
        tick();
        clr_cnt();
        do_start(8'd2);
        wait_done("t5", 100);
        chk("t5_checksum", {24'd0, checksum}, CK ? 32'h01 : 32'h00);
        chk("t5_rd_count", {24'd0, rd_count}, 32'd2);

        // Reset during HOLD of byte 2 of 4
        stall = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        tick();
        clr_cnt();
        do_start(8'd4);
        begin
            bit found;
            int i;
            found = 1'b0;
            i = 0;
            while (!found && i < 100) begin
                @(negedge clk);
                if (m_valid && rd_count == 8'd1) found = 1'b1;
                i++;
            end
            chk("t6_hold2_seen", {31'd0, found}, 32'd1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("t6_rst_m_data", {24'd0, m_data}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_r_en", {31'd0, fifo_r_en}, 32'd0);
        chk("t6_rst_rd_count", {24'd0, rd_count}, 32'd0);
        chk("t6_rst_done", {31'd0, done}, 32'd0);
        chk("t6_rst_checksum", {24'd0, checksum}, 32'd0);
        exp_q.delete();
        stall = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick();
        exp_q.push_back(8'h33);
        clr_cnt();
        do_start(8'd1);
        wait_done("t6", 100);
        chk("t6_rd_count", {24'd0, rd_count}, 32'd1);
        chk("t6_done_cnt", done_cnt, 32'd1);
        chk("t6_exp_left", exp_q.size(), 32'd0);
        chk("t6_checksum", {24'd0, checksum}, CK ? 32'h33 : 32'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
